line_read: RTL and testbench

- AXI4 read master that fetches a horizontal pixel span from the framebuffer and emits it as a pixel stream, one pixel per handshake.
- It is the read-side counterpart of the line fill writer: same request format (base, x, y, w), same framebuffer geometry and same AXI master conventions.
- It sits between the framebuffer AXI interconnect and pixel consumers such as blitter source paths and scanout.

---
 rtl/fb_pkg.sv | 12 +
 rtl/line_read_unpack.sv | 58 +++++
 rtl/line_read.sv | 132 +++++++++++++
 tb/tb_line_read.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer AXI constants, FSM states and span request type shared by fill and read blocks
package fb_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int AXI_ADDR_4K = 4096;
  typedef enum logic [2:0] {IDLE, CALC_0, CALC_1, AR_ISSUE, DRAIN} fb_state_e;
  typedef struct packed {
    logic [31:0] base;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
  } span_req_t;
endpackage

// File: rtl/line_read_unpack.sv
// line_read_unpack: single-word R buffer serialized into pixels, dropping leading skip and trailing excess pixels
module line_read_unpack #(
  parameter int DW = 256,
  parameter int PW = 32,
  parameter int PPW = DW / PW,
  parameter int IW = PPW > 1 ? $clog2(PPW) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [IW-1:0] skip,
  input  logic [15:0]   w,
  input  logic          active,
  input  logic          rvalid,
  input  logic [DW-1:0] rdata,
  output logic          rready,
  output logic [PW-1:0] pix_data,
  output logic          pix_last,
  output logic          pix_valid,
  input  logic          pix_ready
);
  logic buf_valid, first, pix_hs, word_done;
  logic [DW-1:0] buf_data;
  logic [IW-1:0] idx, skip_q;
  logic [15:0] pix_left;
  assign rready = active && !buf_valid;
  assign pix_valid = buf_valid;
  assign pix_last = buf_valid && pix_left == 16'd1;
  assign pix_data = buf_data[idx*PW +: PW];
  assign pix_hs = pix_valid && pix_ready;
  // the word is released on its last pixel or on the span's final pixel, whichever comes first
  assign word_done = pix_left == 16'd1 || 32'(idx) == PPW - 1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      buf_valid <= 1'b0;
      first <= 1'b0;
      buf_data <= '0;
      idx <= '0;
      skip_q <= '0;
      pix_left <= '0;
    end else begin
      if (load) begin
        skip_q <= skip;
        pix_left <= w;
        first <= 1'b1;
      end
      if (rvalid && rready) begin
        buf_valid <= 1'b1;
        buf_data <= rdata;
        idx <= first ? skip_q : '0;
        first <= 1'b0;
      end else if (pix_hs) begin
        pix_left <= pix_left - 16'd1;
        idx <= idx + 1'b1;
        if (word_done) buf_valid <= 1'b0;
      end
    end
endmodule

// File: rtl/line_read.sv
// line_read: AXI4 read master streaming a framebuffer pixel span as one pixel per handshake.
// Define LINE_READ_RRESP_CHECK_EN to enable the sticky rresp error flag on err.
module line_read
  import fb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH = 8,
  parameter int AXI_ID = 0,
  parameter int IMG_WIDTH = 1920,
  parameter int BYTES_PER_PIX = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] req_base_addr,
  input  logic [15:0]               req_x,
  input  logic [15:0]               req_y,
  input  logic [15:0]               req_w,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [AXI_ID_WIDTH-1:0]   axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic [1:0]                axi_arlock,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [BYTES_PER_PIX*8-1:0] pix_data,
  output logic                      pix_last,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      err
);
  localparam int PIX_WIDTH = BYTES_PER_PIX * 8;
  localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
  localparam int PIXS_PER_WORD = BYTES_PER_WORD / BYTES_PER_PIX;
  localparam int STRIDE = IMG_WIDTH * BYTES_PER_PIX;
  localparam int AW1 = AXI_ADDR_WIDTH + 1;
  localparam int OW = $clog2(BYTES_PER_WORD);
  localparam int IW = PIXS_PER_WORD > 1 ? $clog2(PIXS_PER_WORD) : 1;
  fb_state_e state, state_nx;
  span_req_t req_q;
  logic [AW1-1:0] line_off, start, addr, words_left, to_4k, lim, beats;
  logic [IW-1:0] skip;
  logic ar_hs, last_hs, active, load, unused_ok;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = req_valid ? CALC_0 : IDLE;
      CALC_0:   state_nx = CALC_1;
      CALC_1:   state_nx = req_q.w == '0 ? IDLE : AR_ISSUE;
      AR_ISSUE: state_nx = ar_hs && words_left == beats ? DRAIN : AR_ISSUE;
      DRAIN:    state_nx = last_hs ? IDLE : DRAIN;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    axi_arvalid = state == AR_ISSUE;
    active = state == AR_ISSUE || state == DRAIN;
    load = state == CALC_1 && req_q.w != '0;
  end
  // burst length is capped by remaining words, MAX_BURST and the next 4 KiB boundary
  always_comb begin
    start = AW1'(req_q.base) + line_off + AW1'(req_q.x) * AW1'(BYTES_PER_PIX);
    skip = IW'(start[OW-1:0] >> $clog2(BYTES_PER_PIX));
    to_4k = (AW1'(AXI_ADDR_4K) - AW1'(addr[11:0])) >> OW;
    lim = to_4k < AW1'(MAX_BURST) ? to_4k : AW1'(MAX_BURST);
    beats = words_left < lim ? words_left : lim;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      req_q <= '0;
      line_off <= '0;
      addr <= '0;
      words_left <= '0;
    end else begin
      if (req_valid && req_ready) req_q <= '{base: 32'(req_base_addr), x: req_x, y: req_y, w: req_w};
      if (state == CALC_0) line_off <= AW1'(req_q.y) * AW1'(STRIDE);
      if (state == CALC_1) begin
        addr <= {start[AW1-1:OW], OW'(0)};
        words_left <= (AW1'(start[OW-1:0]) + AW1'(req_q.w) * AW1'(BYTES_PER_PIX) + AW1'(BYTES_PER_WORD - 1)) >> OW;
      end
      if (ar_hs) begin
        addr <= addr + (beats << OW);
        words_left <= words_left - beats;
      end
    end
  assign ar_hs = axi_arvalid && axi_arready;
  assign last_hs = pix_valid && pix_ready && pix_last;
  assign axi_arid = AXI_ID_WIDTH'(AXI_ID);
  assign axi_araddr = addr[AXI_ADDR_WIDTH-1:0];
  assign axi_arlen = 8'(beats - 1'b1);
  assign axi_arsize = 3'(OW);
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arlock = '0;
  line_read_unpack #(.DW(AXI_DATA_WIDTH), .PW(PIX_WIDTH)) u_unpack (
    .clk(clk),
    .rstn(rstn),
    .load(load),
    .skip(skip),
    .w(req_q.w),
    .active(active),
    .rvalid(axi_rvalid),
    .rdata(axi_rdata),
    .rready(axi_rready),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );
`ifdef LINE_READ_RRESP_CHECK_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err <= 1'b0;
    else if (axi_rvalid && axi_rready && axi_rresp[1]) err <= 1'b1;
  assign unused_ok = ^{axi_rid, axi_rlast, axi_rresp[0], addr[AW1-1]};
`else
  assign err = 1'b0;
  assign unused_ok = ^{axi_rid, axi_rlast, axi_rresp, addr[AW1-1]};
`endif
endmodule

// File: tb/tb_line_read.sv
// tb_line_read: random AXI slave and span reference model checking line_read pixel and AR streams
module tb_line_read;
  logic clk = 0, rstn = 0;
  logic [31:0] req_base_addr = 0;
  logic [15:0] req_x = 0, req_y = 0, req_w = 0;
  logic req_valid = 0, req_ready;
  logic [7:0] axi_arid, axi_arlen, axi_rid;
  logic [31:0] axi_araddr, pix_data;
  logic [2:0] axi_arsize;
  logic [1:0] axi_arburst, axi_arlock, axi_rresp;
  logic axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic [255:0] axi_rdata;
  logic pix_last, pix_valid, pix_ready, err;
  always #5 clk = ~clk;
  line_read dut (
    .clk(clk), .rstn(rstn),
    .req_base_addr(req_base_addr), .req_x(req_x), .req_y(req_y), .req_w(req_w),
    .req_valid(req_valid), .req_ready(req_ready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .pix_data(pix_data), .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err(err)
  );
  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [31:0] data; logic last;} px_t;
  ar_t exp_ar[$], rq[$];
  px_t exp_px[$];
  int checks = 0, errors = 0;
  int got_px = 0, got_ar = 0, ar_total = 0, stall_at = 0, stall_left = 0;
  bit rnd_ready = 0, bad_pending = 0;
  logic [31:0] seed;
`ifdef LINE_READ_RRESP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  function automatic logic [31:0] pv(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference: pixel k lives at byte base+y*stride+(x+k)*4; bursts split at 16 words and 4 KiB pages
  task automatic model(input logic [31:0] base, input int x, input int y, input int w);
    longint s, a, n, rem, lim;
    s = longint'(base) + longint'(y) * 7680 + longint'(x) * 4;
    for (int k = 0; k < w; k++) exp_px.push_back('{pv(32'(s + k * 4)), k == w - 1});
    if (w > 0) begin
      a = (s / 32) * 32;
      rem = (s + w * 4 - 1) / 32 - s / 32 + 1;
      while (rem > 0) begin
        lim = (4096 - a % 4096) / 32;
        n = rem < 16 ? rem : 16;
        if (lim < n) n = lim;
        exp_ar.push_back('{32'(a), 8'(n - 1)});
        a += n * 32;
        rem -= n;
      end
    end
    ar_total = exp_ar.size();
  endtask
  initial begin
    logic ar_hs, r_hs, st_v, ps_v, ps_l;
    logic [31:0] cur_a, ps_d, r_addr;
    logic [7:0] cur_l;
    int r_left;
    ar_t e, b;
    px_t p;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 0; axi_rlast = 0; axi_rid = 0;
    pix_ready = 1; r_left = 0; r_addr = 0; st_v = 0; ps_v = 0; ps_l = 0; ps_d = 0; cur_a = 0; cur_l = 0;
    forever begin
      @(negedge clk);
      ar_hs = axi_arvalid && axi_arready;
      r_hs = axi_rvalid && axi_rready;
      if (rstn && st_v) begin
        chk("ar_hold_valid", axi_arvalid, 1'b1);
        chk("ar_hold_addr", axi_araddr, cur_a);
        chk("ar_hold_len", axi_arlen, cur_l);
      end
      st_v = axi_arvalid && !axi_arready;
      cur_a = axi_araddr;
      cur_l = axi_arlen;
      if (ar_hs) begin
        got_ar++;
        if (exp_ar.size() == 0) chk("ar_extra", got_ar, ar_total);
        else begin
          e = exp_ar.pop_front();
          chk("ar_addr", axi_araddr, e.addr);
          chk("ar_len", axi_arlen, e.len);
        end
      end
      if (rstn && ps_v) begin
        chk("stall_data", pix_data, ps_d);
        chk("stall_last", pix_last, ps_l);
      end
      if (pix_valid && !pix_ready) chk("rready_stall", axi_rready, 1'b0);
      ps_v = pix_valid && !pix_ready;
      ps_d = pix_data;
      ps_l = pix_last;
      if (pix_valid && pix_ready) begin
        got_px++;
        if (exp_px.size() == 0) chk("pix_extra", got_px, 0);
        else begin
          p = exp_px.pop_front();
          chk("pix_data", pix_data, p.data);
          chk("pix_last", pix_last, p.last);
        end
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        rq.delete();
        r_left = 0; axi_rvalid = 0; axi_arready = 0; st_v = 0; ps_v = 0;
        continue;
      end
      if (ar_hs) rq.push_back('{cur_a, cur_l});
      if (r_hs) begin
        if (axi_rresp[1]) bad_pending = 0;
        r_addr += 32;
        r_left--;
      end
      if (r_left == 0 && rq.size() > 0) begin
        b = rq.pop_front();
        r_addr = b.addr;
        r_left = int'(b.len) + 1;
      end
      if (r_left > 0) begin
        if (r_hs || !axi_rvalid) axi_rvalid = $urandom_range(3) != 0;
        for (int i = 0; i < 8; i++) axi_rdata[i*32 +: 32] = pv(r_addr + 32'(i * 4));
        axi_rlast = r_left == 1;
        axi_rresp = bad_pending ? 2'b10 : 2'b00;
      end else axi_rvalid = 0;
      axi_arready = 1'($urandom_range(1));
      if (stall_left > 0 && got_px >= stall_at) begin
        pix_ready = 0;
        stall_left--;
      end else pix_ready = rnd_ready ? ($urandom_range(4) != 0) : 1'b1;
    end
  end
  task automatic start_span(input logic [31:0] base, input int x, input int y, input int w);
    got_px = 0;
    got_ar = 0;
    model(base, x, y, w);
    @(posedge clk);
    #1;
    req_base_addr = base; req_x = 16'(x); req_y = 16'(y); req_w = 16'(w); req_valid = 1;
    @(negedge clk);
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arvalid_c%0d", c), axi_arvalid, c == 3 && w != 0);
      chk($sformatf("req_ready_c%0d", c), req_ready, c == 3 && w == 0);
    end
  endtask
  task automatic finish_span(input int w);
    int cyc;
    cyc = 0;
    while ((got_px < w || exp_ar.size() > 0 || !req_ready) && cyc < 4000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("span_in_time", cyc < 4000, 1'b1);
    chk("pix_count", got_px, w);
    chk("ar_count", got_ar, ar_total);
  endtask
  task automatic run_span(input logic [31:0] base, input int x, input int y, input int w);
    start_span(base, x, y, w);
    finish_span(w);
  endtask
  initial begin
    int x, w, c;
    seed = $urandom;
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_rready", axi_rready, 1'b0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_last", pix_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("arsize", axi_arsize, 3'd5);
    chk("arburst", axi_arburst, 2'b01);
    chk("arid", axi_arid, 8'd0);
    chk("arlock", axi_arlock, 2'd0);
    @(negedge clk);
    #2;
    rstn = 1;
    run_span(0, 0, 0, 8);
    run_span(0, 3, 1, 10);
    run_span(0, 1000, 0, 100);
    run_span(0, 0, 0, 0);
    chk("w0_no_ar", got_ar, 0);
    stall_at = 30;
    stall_left = 20;
    run_span(0, 0, 0, 64);
    rnd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(1919);
      w = $urandom_range(1, (1920 - x) < 300 ? 1920 - x : 300);
      run_span($urandom_range(255) * 32, x, $urandom_range(1079), w);
    end
    bad_pending = 1;
    run_span(32'h1000, 5, 2, 40);
    chk("err_after_bad_resp", err, ERR_EXP);
    run_span(0, 17, 4, 50);
    chk("err_sticky", err, ERR_EXP);
    start_span(0, 100, 3, 400);
    c = 0;
    while (got_px < 50 && c < 4000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("mid_reached", got_px >= 50, 1'b1);
    rstn = 0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_arvalid", axi_arvalid, 1'b0);
    chk("mid_rst_rready", axi_rready, 1'b0);
    chk("mid_rst_pix_valid", pix_valid, 1'b0);
    chk("mid_rst_pix_last", pix_last, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    exp_px.delete();
    exp_ar.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rstn = 1;
    run_span(0, 7, 9, 77);
    chk("err_after_reset", err, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
